spi_slave: RTL and testbench

SPI peripheral-side endpoint, the responder to the existing SPI master. Samples an external SPI bus (SCLK, MOSI, CS_n) in the local clock domain, assembles MSB-first bytes on MOSI, and shifts out host-supplied bytes on MISO. Provides the same byte-level RX/TX handshake style as the master so SoC logic and benches can pair the two directly (master MOSI→slave MOSI, slave MISO→master MISO).

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync.sv | 26 ++
 rtl/spi_slave.sv | 166 ++++++++++++++++
 tb/tb_spi_slave.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI peripheral endpoint.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  // Sent when the host has not queued a byte before a slot starts.
  localparam logic [7:0] IDLE_MISO_BYTE = 8'hFF;

  function automatic logic cpol(input int mode);
    return ((mode >> 1) & 1) != 0;
  endfunction

  function automatic logic cpha(input int mode);
    return (mode & 1) != 0;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin; the reset value is the pin's inactive level.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_D,
  output logic o_Q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_D;
      sync_q <= meta_q;
    end
  end

  assign o_Q = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversamples SCLK/MOSI/CS_n in the i_Clk domain, assembles
// MSB-first RX bytes and shifts host-queued TX bytes out on MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE         = 0,
  parameter int MAX_BYTES_PER_CS = 2
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst_L,
  output logic                                  o_RX_DV,
  output logic [7:0]                            o_RX_Byte,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_Count,
  input  logic                                  i_TX_DV,
  input  logic [7:0]                            i_TX_Byte,
  output logic                                  o_TX_Ready,
  output logic                                  o_TX_Underrun,
  input  logic                                  i_SPI_Clk,
  input  logic                                  i_SPI_MOSI,
  input  logic                                  i_SPI_CS_n,
  output logic                                  o_SPI_MISO,
  output logic                                  o_SPI_MISO_En
);

  localparam int            CW      = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BYTES_PER_CS);
  localparam logic          CPOL    = cpol(SPI_MODE);
  localparam logic          CPHA    = cpha(SPI_MODE);

  logic sclk_s;
  logic mosi_s;
  logic cs_n_s;

  spi_sync #(.RST_VAL(CPOL)) u_sync_sclk (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_D(i_SPI_Clk), .o_Q(sclk_s)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_D(i_SPI_MOSI), .o_Q(mosi_s)
  );
  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_D(i_SPI_CS_n), .o_Q(cs_n_s)
  );

  state_e        state_q;
  logic [1:0]    prime_q;
  logic          armed_q;
  logic          sclk_prev_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    rx_q;
  logic [7:0]    tx_q;
  logic [7:0]    hold_q;
  logic          hold_full_q;
  logic [7:0]    rx_byte_q;
  logic          rx_dv_q;
  logic [CW-1:0] count_q;
  logic          underrun_q;
  logic          miso_q;
  logic          miso_en_q;

  logic       leading_d;
  logic       trailing_d;
  logic       sample_edge_d;
  logic       shift_edge_d;
  logic [7:0] rx_d;
  logic       byte_done_d;
  logic       reload_d;
  logic [7:0] reload_byte_d;
  logic       tx_accept_d;

  assign leading_d     = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
  assign trailing_d    = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
  assign sample_edge_d = CPHA ? trailing_d : leading_d;
  assign shift_edge_d  = CPHA ? leading_d : trailing_d;
  assign rx_d          = {rx_q, mosi_s};
  assign byte_done_d   = sample_edge_d && (bit_cnt_q == 3'd7);
  assign reload_d      = !cs_n_s && ((state_q == LOAD) || ((state_q == SHIFT) && byte_done_d));
  assign reload_byte_d = hold_full_q ? hold_q : IDLE_MISO_BYTE;
  // A byte offered in a reload cycle is judged against the pre-reload occupancy.
  assign tx_accept_d   = i_TX_DV && !hold_full_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      prime_q     <= 2'b00;
      armed_q     <= 1'b0;
      sclk_prev_q <= CPOL;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= IDLE_MISO_BYTE;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      rx_byte_q   <= 8'd0;
      rx_dv_q     <= 1'b0;
      count_q     <= '0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b1;
      miso_en_q   <= 1'b0;
    end else begin
      rx_dv_q     <= 1'b0;
      underrun_q  <= 1'b0;
      sclk_prev_q <= sclk_s;
      prime_q     <= {prime_q[0], 1'b1};

      if (tx_accept_d) begin
        hold_q      <= i_TX_Byte;
        hold_full_q <= 1'b1;
      end
      if (reload_d) begin
        tx_q       <= reload_byte_d;
        underrun_q <= !hold_full_q;
        if (hold_full_q) hold_full_q <= 1'b0;
      end

      if ((state_q != IDLE) && cs_n_s) begin
        state_q   <= IDLE;
        armed_q   <= 1'b0;
        count_q   <= '0;
        miso_q    <= 1'b1;
        miso_en_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // Only a high CS_n seen after the synchronizers have filled can arm a frame.
            armed_q   <= prime_q[1] & cs_n_s;
            count_q   <= '0;
            miso_q    <= 1'b1;
            miso_en_q <= 1'b0;
            if (armed_q && !cs_n_s) begin
              state_q   <= LOAD;
              miso_en_q <= 1'b1;
            end
          end
          LOAD: begin
            bit_cnt_q <= 3'd0;
            miso_q    <= reload_byte_d[7];
            state_q   <= SHIFT;
          end
          SHIFT: begin
            if (sample_edge_d) begin
              rx_q      <= rx_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (byte_done_d) begin
                rx_byte_q <= rx_d;
                rx_dv_q   <= 1'b1;
                if (count_q != CNT_MAX) count_q <= count_q + CW'(1);
                if (CPHA) miso_q <= reload_byte_d[7];
              end
            end else if (shift_edge_d && !(CPHA && (bit_cnt_q == 3'd0))) begin
              miso_q <= tx_q[~bit_cnt_q];
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_Count    = count_q;
  assign o_TX_Ready    = !hold_full_q;
  assign o_TX_Underrun = underrun_q;
  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = miso_en_q;

endmodule

// File: tb/tb_spi_slave.sv
// Drives all four SPI modes in lockstep from a bit-level master model and checks
// RX bytes, frame counts, MISO bytes and underruns against a byte-slot reference model.
module tb_spi_slave;

  localparam int H    = 8;
  localparam int MAXB = 2;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int NLOG = 64;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       cs_n    = 1'b1;
  logic [3:0] sclk    = 4'b1100;
  logic [3:0] mosi    = 4'b0000;
  logic       tx_dv   = 1'b0;
  logic [7:0] tx_byte = 8'h00;

  logic [3:0]    rx_dv, tx_ready, underrun, miso, miso_en;
  logic [7:0]    rx_byte [4];
  logic [CW-1:0] rx_cnt  [4];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      spi_slave #(.SPI_MODE(gi), .MAX_BYTES_PER_CS(MAXB)) u_dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .o_RX_DV      (rx_dv[gi]),
        .o_RX_Byte    (rx_byte[gi]),
        .o_RX_Count   (rx_cnt[gi]),
        .i_TX_DV      (tx_dv),
        .i_TX_Byte    (tx_byte),
        .o_TX_Ready   (tx_ready[gi]),
        .o_TX_Underrun(underrun[gi]),
        .i_SPI_Clk    (sclk[gi]),
        .i_SPI_MOSI   (mosi[gi]),
        .i_SPI_CS_n   (cs_n),
        .o_SPI_MISO   (miso[gi]),
        .o_SPI_MISO_En(miso_en[gi])
      );
    end
  endgenerate

  // Monitor: log every RX_DV pulse and count underrun pulses per mode.
  logic [7:0] log_byte [4][NLOG];
  int         log_cnt  [4][NLOG];
  int         log_n    [4] = '{0, 0, 0, 0};
  int         urun_n   [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_dv[k] && log_n[k] < NLOG) begin
        log_byte[k][log_n[k]] = rx_byte[k];
        log_cnt[k][log_n[k]]  = int'(rx_cnt[k]);
        log_n[k]++;
      end
      if (underrun[k]) urun_n[k]++;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: single-entry holding register seen at byte-slot granularity.
  bit         m_full = 1'b0;
  logic [7:0] m_val  = 8'h00;

  logic [7:0] mtx [8];
  logic [7:0] mrx [4][9];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rx_dv"},    32'(rx_dv),    32'h0);
    check({tag, " tx_ready"}, 32'(tx_ready), 32'hF);
    check({tag, " underrun"}, 32'(underrun), 32'h0);
    check({tag, " miso"},     32'(miso),     32'hF);
    check({tag, " miso_en"},  32'(miso_en),  32'h0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s m%0d rx_byte", tag, k), 32'(rx_byte[k]), 32'h0);
      check($sformatf("%s m%0d rx_cnt", tag, k),  32'(rx_cnt[k]),  32'h0);
    end
  endtask

  task automatic load(input logic [7:0] b, input string tag);
    tx_dv   = 1'b1;
    tx_byte = b;
    tick(1);
    tx_dv = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_val  = b;
    end
    tick(1);
    check({tag, " tx_ready"}, 32'(tx_ready), 32'h0);
  endtask

  // Bit-level master: CPHA=0 buses present MOSI half a bit before the leading edge,
  // CPHA=1 buses present it on the leading edge; MISO is read just before each sample edge.
  task automatic run_frame(input int nbits, input int rst_at);
    int bi;
    logic b;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 9; j++) mrx[k][j] = 8'h00;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bi = i / 8;
      b  = mtx[bi][7 - (i % 8)];
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(1);
        check_reset("midrst");
        tick(2);
        rst_n  = 1'b1;
        m_full = 1'b0;
      end
      mosi[0] = b;
      mosi[2] = b;
      tick(H);
      if (i == 0) check("frame miso_en", 32'(miso_en), 32'hF);
      mrx[0][bi] = {mrx[0][bi][6:0], miso[0]};
      mrx[2][bi] = {mrx[2][bi][6:0], miso[2]};
      sclk    = ~sclk;
      mosi[1] = b;
      mosi[3] = b;
      tick(H);
      mrx[1][bi] = {mrx[1][bi][6:0], miso[1]};
      mrx[3][bi] = {mrx[3][bi][6:0], miso[3]};
      sclk = ~sclk;
    end
    tick(H);
    cs_n = 1'b1;
    tick(3 * H);
  endtask

  task automatic do_frame(input string tag, input int nbits);
    int         done;
    int         exp_ur;
    int         base_n [4];
    int         base_u [4];
    logic [7:0] exp_tx [9];
    done   = nbits / 8;
    exp_ur = 0;
    // One slot opens at frame start and another after every completed byte,
    // including the last one, so an empty holding register underruns there too.
    for (int s = 0; s <= done; s++) begin
      if (m_full) begin
        exp_tx[s] = m_val;
        m_full    = 1'b0;
      end else begin
        exp_tx[s] = 8'hFF;
        exp_ur++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      base_n[k] = log_n[k];
      base_u[k] = urun_n[k];
    end
    run_frame(nbits, -1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s m%0d dv_count", tag, k), 32'(log_n[k] - base_n[k]), 32'(done));
      for (int i = 0; i < done; i++) begin
        check($sformatf("%s m%0d b%0d rx_byte", tag, k, i),
              32'(log_byte[k][base_n[k] + i]), 32'(mtx[i]));
        check($sformatf("%s m%0d b%0d rx_cnt", tag, k, i),
              32'(log_cnt[k][base_n[k] + i]), 32'((i + 1 < MAXB) ? i + 1 : MAXB));
        check($sformatf("%s m%0d b%0d miso_byte", tag, k, i), 32'(mrx[k][i]), 32'(exp_tx[i]));
      end
      check($sformatf("%s m%0d underruns", tag, k), 32'(urun_n[k] - base_u[k]), 32'(exp_ur));
      check($sformatf("%s m%0d idle_cnt", tag, k), 32'(rx_cnt[k]), 32'h0);
    end
    check({tag, " idle miso"},    32'(miso),    32'hF);
    check({tag, " idle miso_en"}, 32'(miso_en), 32'h0);
  endtask

  initial begin
    int base_n [4];
    int base_u [4];
    int nb;

    tick(2);
    check_reset("reset");
    rst_n = 1'b1;
    tick(4);

    // Loopback-style frame: 0x81 queued, two bytes sent.
    load(8'h81, "pre81");
    mtx[0] = 8'hA5;
    mtx[1] = 8'h3C;
    do_frame("loop", 16);

    // Second offer while full is dropped.
    load(8'h11, "dbl1");
    load(8'h22, "dbl2");
    mtx[0] = 8'h5A;
    do_frame("dbl", 8);

    // Frame aborted after four bits, then a clean frame.
    mtx[0] = 8'hF0;
    do_frame("cut", 4);
    mtx[0] = 8'h55;
    do_frame("after_cut", 8);

    // Reset mid-byte with CS_n held low: the rest of the frame must be ignored.
    load(8'h77, "pre77");
    mtx[0] = 8'hA0;
    mtx[1] = 8'h0F;
    m_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      base_n[k] = log_n[k];
      base_u[k] = urun_n[k];
    end
    run_frame(16, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rstframe m%0d dv_count", k), 32'(log_n[k] - base_n[k]), 32'h0);
      check($sformatf("rstframe m%0d underruns", k), 32'(urun_n[k] - base_u[k]), 32'h0);
    end
    check("rstframe tx_ready", 32'(tx_ready), 32'hF);
    mtx[0] = 8'hC3;
    do_frame("post_rst", 8);

    // Three bytes in one frame: count saturates at MAXB.
    load(8'h6B, "pre6B");
    mtx[0] = 8'h12;
    mtx[1] = 8'h34;
    mtx[2] = 8'h56;
    do_frame("three", 24);

    // Randomized frames.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) != 0) load(8'($urandom_range(0, 255)), $sformatf("rnd%0d ld", r));
      nb = int'($urandom_range(1, 3));
      for (int i = 0; i < nb; i++) mtx[i] = 8'($urandom_range(0, 255));
      do_frame($sformatf("rnd%0d", r), nb * 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
